// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock divider with shadowed configuration.
// Each channel produces a divided clock, a period tick and a pending flag.
module prog_clk_div #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 26,
    parameter int DEFAULT_DIV = 50_000_000
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [CHANNELS-1:0]                          en,
    input  logic                                         sync_restart,
    input  logic                                         wr_en,
    input  logic [$clog2(CHANNELS > 1 ? CHANNELS : 2)-1:0] wr_ch,
    input  logic [WIDTH-1:0]                             wr_div,
    input  logic [WIDTH-1:0]                             wr_high,
    output logic [CHANNELS-1:0]                          out,
    output logic [CHANNELS-1:0]                          tick,
    output logic [CHANNELS-1:0]                          pending
);

    localparam int CW = $clog2(CHANNELS > 1 ? CHANNELS : 2);
    localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(DEFAULT_DIV / 2);
    localparam logic [WIDTH-1:0] MIN_DIV  = WIDTH'(2);

    logic [WIDTH-1:0] wdiv;

    // Divisors below 2 cannot form a period; raise them to 2.
    always_comb begin
        wdiv = (wr_div < MIN_DIV) ? MIN_DIV : wr_div;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] act_div;
        logic [WIDTH-1:0] act_high;
        logic [WIDTH-1:0] sh_div;
        logic [WIDTH-1:0] sh_high;
        logic [WIDTH-1:0] phase;
        logic [WIDTH-1:0] p_next;
        logic [WIDTH-1:0] nxt_high;
        logic             parked;
        logic             pend;
        logic             o;
        logic             t;
        logic             hit;
        logic             wrap;

        // Out-of-range channel numbers never match, so such writes drop.
        assign hit = wr_en && (wr_ch == CW'(i));

        // Period boundary detection and the high count for a new period.
        always_comb begin
            wrap     = parked | sync_restart | (phase >= act_div - 1'b1);
            p_next   = phase + 1'b1;
            nxt_high = pend ? sh_high : act_high;
        end

        // Phase, configuration and registered outputs of one channel.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                act_div  <= RST_DIV;
                act_high <= RST_HIGH;
                sh_div   <= RST_DIV;
                sh_high  <= RST_HIGH;
                phase    <= '0;
                parked   <= 1'b1;
                pend     <= 1'b0;
                o        <= 1'b0;
                t        <= 1'b0;
            end else if (!en[i]) begin
                parked <= 1'b1;
                phase  <= '0;
                o      <= 1'b0;
                t      <= 1'b0;
                if (hit) begin
                    act_div  <= wdiv;
                    act_high <= wr_high;
                    sh_div   <= wdiv;
                    sh_high  <= wr_high;
                    pend     <= 1'b0;
                end
            end else begin
                parked <= 1'b0;
                if (wrap) begin
                    phase <= '0;
                    t     <= 1'b1;
                    o     <= (nxt_high != '0);
                    pend  <= 1'b0;
                    if (pend) begin
                        act_div  <= sh_div;
                        act_high <= sh_high;
                    end
                end else begin
                    phase <= p_next;
                    t     <= 1'b0;
                    o     <= (p_next < act_high);
                end
                if (hit) begin
                    sh_div  <= wdiv;
                    sh_high <= wr_high;
                    pend    <= 1'b1;
                end
            end
        end

        assign out[i]     = o;
        assign tick[i]    = t;
        assign pending[i] = pend;
    end

endmodule
